// File: rtl/seg7_scan_driver_if.sv
// Purpose: display-side bundle between a result register bank and the scan driver.
// Latency: wires only; no storage.
// Backpressure: none; load is a fire-and-forget strobe, the driver always accepts it.
//
// Signals: value/dp/lz_blank/load/blank flow toward the driver (master drives them);
// seg/dp_out/an/frame_tick flow back toward the board pins (slave drives them).
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;       // packed hex digits, nibble i -> digit i
    logic [DIGITS-1:0]   dp;          // decimal-point enables, bit i -> digit i
    logic                lz_blank;    // leading-zero blanking enable
    logic                load;        // one-cycle capture strobe
    logic                blank;       // unbuffered force-dark
    logic [6:0]          seg;         // {g,f,e,d,c,b,a}, physical polarity
    logic                dp_out;      // decimal point, physical polarity
    logic [DIGITS-1:0]   an;          // one-hot anode enable, physical polarity
    logic                frame_tick;  // pulse after the scan wraps to digit 0

    modport master (
        output value, dp, lz_blank, load, blank,
        input  seg, dp_out, an, frame_tick
    );

    modport slave (
        input  value, dp, lz_blank, load, blank,
        output seg, dp_out, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed hex display driver, double-buffered, with lz/global blanking.
// Latency: all outputs registered, one cycle after idx/active content/blank change.
// Backpressure: none; loads are always accepted and promoted only on frame wrap.
//
// Ports: clk, resetn (synchronous, active-low); disp (slave modport) carries the
// value/dp/lz_blank/load/blank inputs and seg/dp_out/an/frame_tick outputs.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    seg7_scan_driver_if.slave   disp
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;

    // scan position
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tc, wrap;

    // pending and active display content
    logic              pend_q, pend_d;
    logic [VW-1:0]     pval_q, pval_d, aval_q, aval_d;
    logic [DIGITS-1:0] pdp_q, pdp_d, adp_q, adp_d;
    logic              plz_q, plz_d, alz_q, alz_d;

    // registered pin drivers
    logic [6:0]        seg_q, seg_d;
    logic              dpo_q, dpo_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              ft_q, ft_d;

    // decode intermediates
    logic [3:0]        nib;
    logic              dp_sel;
    logic              dark;
    logic              zero_run;
    logic [6:0]        seg_hi;
    logic              dp_hi;
    logic [DIGITS-1:0] an_hi;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h67;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign tc   = (pcnt_q == PW'(PRESCALE - 1));
    assign wrap = tc && (idx_q == IW'(DIGITS - 1));

    // scan counters and buffer promotion
    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        pend_d = pend_q;
        pval_d = pval_q;
        pdp_d  = pdp_q;
        plz_d  = plz_q;
        aval_d = aval_q;
        adp_d  = adp_q;
        alz_d  = alz_q;

        if (tc) begin
            pcnt_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end

        // A load landing on the wrap goes straight to active so it is shown
        // from the very first digit of the new frame.
        if (disp.load && wrap) begin
            aval_d = disp.value;
            adp_d  = disp.dp;
            alz_d  = disp.lz_blank;
            pend_d = 1'b0;
        end else if (disp.load) begin
            pval_d = disp.value;
            pdp_d  = disp.dp;
            plz_d  = disp.lz_blank;
            pend_d = 1'b1;
        end else if (wrap && pend_q) begin
            aval_d = pval_q;
            adp_d  = pdp_q;
            alz_d  = plz_q;
            pend_d = 1'b0;
        end
    end

    // digit select, leading-zero detection and glyph decode
    always_comb begin
        nib      = 4'h0;
        dp_sel   = 1'b0;
        dark     = 1'b0;
        zero_run = 1'b1;
        an_hi    = '0;

        // Walk from the most significant digit down; zero_run stays set only
        // while every nibble seen so far is zero, i.e. the digit is a leading zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (aval_q[i*4 +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib      = aval_q[i*4 +: 4];
                dp_sel   = adp_q[i];
                dark     = alz_q & zero_run & (i != 0);
                an_hi[i] = 1'b1;
            end
        end

        // dark digits keep their anode so the scan duty stays constant
        seg_hi = dark ? 7'h00 : glyph(nib);
        dp_hi  = dark ? 1'b0 : dp_sel;

        if (disp.blank) begin
            seg_hi = 7'h00;
            dp_hi  = 1'b0;
            an_hi  = '0;
        end

        seg_d = seg_hi ^ {7{ACTIVE_LOW}};
        dpo_d = dp_hi ^ ACTIVE_LOW;
        an_d  = an_hi ^ {DIGITS{ACTIVE_LOW}};
        ft_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcnt_q <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            pval_q <= '0;
            pdp_q  <= '0;
            plz_q  <= 1'b0;
            aval_q <= '0;
            adp_q  <= '0;
            alz_q  <= 1'b0;
            seg_q  <= {7{ACTIVE_LOW}};
            dpo_q  <= ACTIVE_LOW;
            an_q   <= {DIGITS{ACTIVE_LOW}};
            ft_q   <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            pval_q <= pval_d;
            pdp_q  <= pdp_d;
            plz_q  <= plz_d;
            aval_q <= aval_d;
            adp_q  <= adp_d;
            alz_q  <= alz_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            an_q   <= an_d;
            ft_q   <= ft_d;
        end
    end

    assign disp.seg        = seg_q;
    assign disp.dp_out     = dpo_q;
    assign disp.an         = an_q;
    assign disp.frame_tick = ft_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for DIGITS hex digits sharing one segment bus. It double-buffers a packed hex value, scans the digit anodes at a programmable rate, and decodes each nibble to segments. It supports per-digit decimal points, leading-zero blanking, global blanking and selectable output polarity. It sits between datapath result registers and the board display pins, and supersedes single-digit static decoding wherever more than one digit shares the segment lines.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (2..8); digit DIGITS-1 is the most significant.
- PRESCALE, 50000, clock cycles each digit is enabled (≥2).
- ACTIVE_LOW, 1, 1 = seg, dp_out and an are driven active-low; 0 = active-high.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- value  in  4*DIGITS  packed hex digits; nibble i drives digit i.
- dp  in  DIGITS  decimal-point enables, bit i belongs to digit i.
- lz_blank  in  1  leading-zero blanking enable; captured together with value.
- load  in  1  one-cycle strobe that captures value, dp and lz_blank.
- blank  in  1  forces all digits dark while high; not buffered.
- seg  out  7  segments {g,f,e,d,c,b,a} in physical polarity.
- dp_out  out  1  decimal-point segment in physical polarity.
- an  out  DIGITS  one-hot digit enable in physical polarity.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1. At the terminal count (tc), pcnt returns to 0 and digit index idx advances modulo DIGITS.
- A wrap is tc while idx == DIGITS-1. On a wrap:
  - frame_tick is high for the following cycle.
  - pending content is promoted to active.
- Buffering:
  - load copies value, dp and lz_blank into a pending buffer and sets pend.
  - A load while pend is set overwrites the pending buffer; last load wins.
  - On a wrap with pend set, active takes the pending buffer and pend clears.
  - A load in the same cycle as a wrap bypasses the pending buffer: active takes the inputs directly and pend clears.
  - Active content changes only at frame boundaries, so a frame never mixes old and new values.
- Glyphs (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blanking: when active lz_blank=1, digit i (i≥1) is dark if active nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked this way.
- A dark digit drives all segments off and dp off. Its anode stays enabled, so scan duty is unchanged.
- blank=1 forces all anodes, segments and dp off. Scanning and buffering continue underneath.
- When ACTIVE_LOW=1, seg, dp_out and an are the bitwise inverse of the active-high values.

## Timing
- Reset (resetn low at a clock edge):
  - pcnt=0, idx=0, pend=0.
  - Active and pending value=0, dp=0, lz_blank=0.
  - Outputs: frame_tick=0; seg, dp_out and an all off in physical polarity (ACTIVE_LOW=1 gives seg=7F, dp_out=1, an all ones).
- Reset asserted mid-frame or mid-load discards pending and active content. No partial update is ever promoted.
- All outputs are registered and reflect idx, active content and blank one cycle after they change.
- After reset release, the first output edge enables digit 0 and shows glyph 0.
- Each digit is enabled for exactly PRESCALE cycles. A frame is DIGITS*PRESCALE cycles. frame_tick has period DIGITS*PRESCALE.
- load-to-display latency:
  - Maximum: one frame plus one cycle.
  - Minimum: one cycle, when load coincides with a wrap.
- blank takes effect and releases with one cycle latency.
- No overlap or gap is allowed between anodes. Exactly one anode is on per cycle unless blank or reset forces all off.

## Test plan
- Reset/idle (DIGITS=4, PRESCALE=4, ACTIVE_LOW=1): hold resetn low 3 cycles, release → seg=7F, an=F on the reset cycle; then an cycles E,D,B,7 with 4 cycles each; digit 0 seg=40; frame_tick every 16 cycles.
- Decode sweep: load value=0x3210, then 0x7654, 0xBA98, 0xFEDC, one per frame → each digit's seg equals the inverse of the glyph table for all 16 nibbles.
- Buffering: load 0x1234 mid-frame, then load 0xABCD before the wrap → no change within the current frame; the next frame shows ABCD only. A load on the wrap cycle shows the new value one cycle later.
- Leading zeros: load value=0x0005 with lz_blank=1 → digits 3..1 dark (seg=7F), digit 0 shows 6D inverted. value=0x0000 → only digit 0 lit showing "0". value=0x0105 → only digit 3 dark.
- dp and blank: dp=4'b0100 → dp_out=0 only while an=B. Pulse blank for 5 cycles mid-frame → an=F for exactly those cycles (shifted by one), and scan phase is unchanged afterward.
- Polarity/width: DIGITS=8, ACTIVE_LOW=0, reset mid-frame → outputs 0 during reset, an restarts at 01, value 0; frame period 8*PRESCALE.
